// File: rtl/alu_operand_stage_pkg.sv
// alu_op_pkg: shared widths and operand-select encodings for the ID->EX operand stage
package alu_op_pkg;
    localparam int XLEN_DEF = 32;
    localparam int REGW_DEF = 5;
    localparam int NFWD_DEF = 2;
    localparam int CNTW_DEF = 16;
    typedef logic [XLEN_DEF-1:0] operand_t;
    typedef enum logic {A_RS1 = 1'b0, A_PC  = 1'b1} asel_e;
    typedef enum logic {B_RS2 = 1'b0, B_IMM = 1'b1} bsel_e;
endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// fwd_mux: priority bypass of one source register from the in-flight producers
module fwd_mux
    import alu_op_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int REGW = REGW_DEF,
    parameter int NFWD = NFWD_DEF
) (
    input  logic [REGW-1:0]      i_addr,
    input  logic [XLEN-1:0]      i_rf_data,
    input  logic [NFWD-1:0]      i_fwd_valid,
    input  logic [NFWD-1:0]      i_fwd_pend,
    input  logic [NFWD*REGW-1:0] i_fwd_addr,
    input  logic [NFWD*XLEN-1:0] i_fwd_data,
    output logic [XLEN-1:0]      o_data,
    output logic                 o_hazard
);
    // Scan oldest to youngest so the lowest matching index overrides; x0 is forced to zero
    always_comb begin
        o_data   = i_rf_data;
        o_hazard = 1'b0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (i_fwd_valid[i] && i_fwd_addr[i*REGW +: REGW] == i_addr) begin
                o_data   = i_fwd_data[i*XLEN +: XLEN];
                o_hazard = i_fwd_pend[i];
            end
        end
        if (i_addr == '0) begin
            o_data   = '0;
            o_hazard = 1'b0;
        end
    end
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: registered operand select with bypass, load-use stall, flush and stall counter
module alu_operand_stage
    import alu_op_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int REGW = REGW_DEF,
    parameter int NFWD = NFWD_DEF,
    parameter int CNTW = CNTW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REGW-1:0]      in_rs1_addr,
    input  logic [REGW-1:0]      in_rs2_addr,
    input  logic [XLEN-1:0]      in_rs1_data,
    input  logic [XLEN-1:0]      in_rs2_data,
    input  logic [XLEN-1:0]      in_imm,
    input  logic [XLEN-1:0]      in_pc,
    input  logic                 in_asel,
    input  logic                 in_bsel,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD-1:0]      fwd_pend,
    input  logic [NFWD*REGW-1:0] fwd_addr,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_a,
    output logic [XLEN-1:0]      out_b,
    output logic [XLEN-1:0]      out_store,
    output logic [CNTW-1:0]      stall_cnt
);
    logic [XLEN-1:0] w_rs1, w_rs2, w_a, w_b;
    logic            w_rs1_hz, w_rs2_hz, w_hazard, w_accept;
    logic            r_valid;
    logic [XLEN-1:0] r_a, r_b, r_store;
    logic [CNTW-1:0] r_cnt;

    fwd_mux #(.XLEN(XLEN), .REGW(REGW), .NFWD(NFWD)) u_fwd_rs1 (
        .i_addr(in_rs1_addr), .i_rf_data(in_rs1_data),
        .i_fwd_valid(fwd_valid), .i_fwd_pend(fwd_pend),
        .i_fwd_addr(fwd_addr), .i_fwd_data(fwd_data),
        .o_data(w_rs1), .o_hazard(w_rs1_hz)
    );

    fwd_mux #(.XLEN(XLEN), .REGW(REGW), .NFWD(NFWD)) u_fwd_rs2 (
        .i_addr(in_rs2_addr), .i_rf_data(in_rs2_data),
        .i_fwd_valid(fwd_valid), .i_fwd_pend(fwd_pend),
        .i_fwd_addr(fwd_addr), .i_fwd_data(fwd_data),
        .o_data(w_rs2), .o_hazard(w_rs2_hz)
    );

    // rs1 only matters when A uses it; rs2 always matters because it is the store data
    always_comb begin
        w_hazard = (w_rs1_hz && asel_e'(in_asel) == A_RS1) || w_rs2_hz;
        in_ready = (!r_valid || out_ready) && !w_hazard;
        w_accept = in_valid && in_ready;
        w_a      = asel_e'(in_asel) == A_PC  ? in_pc  : w_rs1;
        w_b      = bsel_e'(in_bsel) == B_IMM ? in_imm : w_rs2;
    end

    // Pipeline register: flush dominates, then accept, then consume empties the stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_store <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_a     <= w_a;
            r_b     <= w_b;
            r_store <= w_rs2;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Saturating count of cycles an instruction waits on a pending producer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (in_valid && w_hazard && !flush && r_cnt != '1)
            r_cnt <= r_cnt + 1'b1;
    end

    assign out_valid = r_valid;
    assign out_a     = r_a;
    assign out_b     = r_b;
    assign out_store = r_store;
    assign stall_cnt = r_cnt;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed scenario checks for the operand stage
module tb_alu_operand_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [4:0]  in_rs1_addr, in_rs2_addr;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
    logic        in_asel, in_bsel;
    logic [1:0]  fwd_valid, fwd_pend;
    logic [9:0]  fwd_addr;
    logic [63:0] fwd_data;
    logic        flush, out_valid, out_ready;
    logic [31:0] out_a, out_b, out_store;
    logic [15:0] stall_cnt;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_pc(in_pc), .in_asel(in_asel), .in_bsel(in_bsel),
        .fwd_valid(fwd_valid), .fwd_pend(fwd_pend), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_store(out_store), .stall_cnt(stall_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic no_fwd();
        fwd_valid = 2'b00;
        fwd_pend  = 2'b00;
        fwd_addr  = '0;
        fwd_data  = '0;
    endtask

    task automatic beat(input logic [4:0] r1, input logic [31:0] d1, input logic [4:0] r2, input logic [31:0] d2);
        in_rs1_addr = r1;
        in_rs1_data = d1;
        in_rs2_addr = r2;
        in_rs2_data = d2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        in_asel = 1'b0; in_bsel = 1'b0; in_imm = '0; in_pc = '0;
        beat(5'd0, 32'h0, 5'd0, 32'h0);
        no_fwd();
        #12;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b exp 0", out_valid); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt: got %0d exp 0", stall_cnt); end
        total++; if ({out_a, out_b, out_store} !== 96'd0) begin bad++; $display("FAIL rst_data: got %h %h %h exp 0", out_a, out_b, out_store); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_no_hazard();
        beat(5'd5, 32'h10, 5'd6, 32'h20);
        in_valid = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL nohz_ready: got %b exp 1", in_ready); end
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL nohz_valid: got %b exp 1", out_valid); end
        total++; if (out_a !== 32'h10) begin bad++; $display("FAIL nohz_a: got %h exp 00000010", out_a); end
        total++; if (out_b !== 32'h20) begin bad++; $display("FAIL nohz_b: got %h exp 00000020", out_b); end
        total++; if (out_store !== 32'h20) begin bad++; $display("FAIL nohz_store: got %h exp 00000020", out_store); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL nohz_drain: got %b exp 0", out_valid); end
    endtask

    task automatic test_priority();
        beat(5'd5, 32'h10, 5'd6, 32'h20);
        fwd_valid = 2'b11;
        fwd_addr  = {5'd5, 5'd5};
        fwd_data  = {32'hBB, 32'hAA};
        in_bsel = 1'b1; in_imm = 32'hFFFF_FFFC;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_bsel = 1'b0;
        no_fwd();
        total++; if (out_a !== 32'hAA) begin bad++; $display("FAIL prio_a: got %h exp 000000aa", out_a); end
        total++; if (out_b !== 32'hFFFF_FFFC) begin bad++; $display("FAIL prio_b: got %h exp fffffffc", out_b); end
        total++; if (out_store !== 32'h20) begin bad++; $display("FAIL prio_store: got %h exp 00000020", out_store); end
        fwd_valid = 2'b10;
        fwd_addr  = {5'd6, 5'd0};
        fwd_data  = {32'hCC, 32'h0};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        no_fwd();
        total++; if (out_store !== 32'hCC) begin bad++; $display("FAIL fwd1_store: got %h exp 000000cc", out_store); end
        step();
    endtask

    task automatic test_x0_pc();
        beat(5'd0, 32'h1234, 5'd6, 32'h20);
        fwd_valid = 2'b01;
        fwd_addr  = {5'd0, 5'd0};
        fwd_data  = {32'h0, 32'h55};
        in_asel = 1'b0; in_valid = 1'b1;
        step();
        total++; if (out_a !== 32'h0) begin bad++; $display("FAIL x0_a: got %h exp 00000000", out_a); end
        in_asel = 1'b1; in_pc = 32'h100;
        step();
        in_valid = 1'b0; in_asel = 1'b0;
        no_fwd();
        total++; if (out_a !== 32'h100) begin bad++; $display("FAIL pc_a: got %h exp 00000100", out_a); end
        step();
    endtask

    task automatic test_load_use();
        beat(5'd1, 32'h1, 5'd6, 32'h20);
        in_asel = 1'b1; in_pc = 32'h200;
        fwd_valid = 2'b01; fwd_pend = 2'b01;
        fwd_addr  = {5'd0, 5'd6};
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL lu_ready%0d: got %b exp 0", k, in_ready); end
            step();
        end
        total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL lu_cnt: got %0d exp 3", stall_cnt); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble: got %b exp 0", out_valid); end
        fwd_pend = 2'b00;
        fwd_data = {32'h0, 32'h77};
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL lu_release: got %b exp 1", in_ready); end
        step();
        in_valid = 1'b0; in_asel = 1'b0;
        no_fwd();
        total++; if (out_b !== 32'h77) begin bad++; $display("FAIL lu_b: got %h exp 00000077", out_b); end
        total++; if (out_a !== 32'h200) begin bad++; $display("FAIL lu_a: got %h exp 00000200", out_a); end
        total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL lu_cnt_hold: got %0d exp 3", stall_cnt); end
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        beat(5'd1, 32'h1, 5'd2, 32'h2);
        in_valid = 1'b1;
        step();
        beat(5'd1, 32'h3, 5'd2, 32'h4);
        for (int k = 0; k < 4; k++) begin
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready%0d: got %b exp 0", k, in_ready); end
            total++; if ({out_valid, out_a, out_b, out_store} !== {1'b1, 32'h1, 32'h2, 32'h2}) begin
                bad++; $display("FAIL bp_hold%0d: got %b %h %h %h exp 1 1 2 2", k, out_valid, out_a, out_b, out_store);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release: got %b exp 1", in_ready); end
        step();
        total++; if ({out_valid, out_a, out_b} !== {1'b1, 32'h3, 32'h4}) begin bad++; $display("FAIL b2b_1: got %b %h %h exp 1 3 4", out_valid, out_a, out_b); end
        beat(5'd1, 32'h5, 5'd2, 32'h6);
        step();
        in_valid = 1'b0;
        total++; if ({out_valid, out_a, out_b} !== {1'b1, 32'h5, 32'h6}) begin bad++; $display("FAIL b2b_2: got %b %h %h exp 1 5 6", out_valid, out_a, out_b); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %b exp 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        beat(5'd1, 32'h9, 5'd2, 32'hA);
        in_valid = 1'b1;
        step();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fl_pre: got %b exp 1", out_valid); end
        beat(5'd1, 32'hB, 5'd2, 32'hC);
        out_ready = 1'b1; flush = 1'b1;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_valid: got %b exp 0", out_valid); end
        fwd_valid = 2'b01; fwd_pend = 2'b01; fwd_addr = {5'd0, 5'd2};
        step();
        total++; if ({out_valid, stall_cnt} !== {1'b0, 16'd3}) begin bad++; $display("FAIL fl_hazard: got %b %0d exp 0 3", out_valid, stall_cnt); end
        flush = 1'b0; in_valid = 1'b0;
        no_fwd();
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        beat(5'd1, 32'hD, 5'd2, 32'hE);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        total++; if ({out_valid, stall_cnt} !== {1'b1, 16'd3}) begin bad++; $display("FAIL rm_pre: got %b %0d exp 1 3", out_valid, stall_cnt); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({out_valid, stall_cnt} !== {1'b0, 16'd0}) begin bad++; $display("FAIL rm_async: got %b %0d exp 0 0", out_valid, stall_cnt); end
        total++; if (out_a !== 32'h0) begin bad++; $display("FAIL rm_a: got %h exp 00000000", out_a); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_no_hazard();
        test_priority();
        test_x0_pc();
        test_load_use();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
